conv_window_gen: RTL and testbench

//  Upstream neighbour of edge_conv: turns a raster pixel stream (dstream, one pixel/beat) into 3x3 windows.
//  Two line buffers plus a 3x3 shift-register window; emits one window per accepted pixel once two rows and two columns are primed.

---
 rtl/conv_pkg.sv | 15 +
 rtl/dstream.sv | 9 +
 rtl/line_buffer_ram.sv | 22 ++
 rtl/conv_window_gen.sv | 105 ++++++++++
 tb/tb_conv_window_gen.sv | 325 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/conv_pkg.sv
// Shared types and defaults for the 3x3 window generator and its line buffers.
package conv_pkg;
  localparam int PIX_W     = 30;
  localparam int WIN_TAPS  = 9;
  localparam int IMG_W_DEF = 640;
  localparam int IMG_H_DEF = 480;

  typedef logic [PIX_W-1:0]      pixel_t;
  typedef pixel_t [WIN_TAPS-1:0] window_t;

  // Counter/address width for a range of n values, never narrower than one bit.
  function automatic int addr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/dstream.sv
// Single-beat valid/ready data stream used between pixel pipeline stages.
interface dstream #(parameter int N = 30);
  logic [N-1:0] data;
  logic         valid;
  logic         ready;

  modport source (output data, output valid, input ready);
  modport sink   (input data, input valid, output ready);
endinterface

// File: rtl/line_buffer_ram.sv
// One-line pixel store: 1 write port, 1 registered read port, read-before-write.
module line_buffer_ram
  import conv_pkg::*;
#(
  parameter int DEPTH = IMG_W_DEF,
  parameter int WIDTH = PIX_W,
  parameter int AW    = addr_w(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end
endmodule

// File: rtl/conv_window_gen.sv
// Raster pixel stream to 3x3 window stream using two line buffers and a shift window.
// Optional WIN_SOF_EN adds y_sof, flagging the first window of each frame.
module conv_window_gen
  import conv_pkg::*;
#(
  parameter int W     = 30,
  parameter int IMG_W = IMG_W_DEF,
  parameter int IMG_H = IMG_H_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  dstream.sink                  x,
  output logic [WIN_TAPS*W-1:0] y_win,
  output logic                  y_valid,
  input  logic                  y_ready
`ifdef WIN_SOF_EN
  ,
  output logic                  y_sof
`endif
);
  localparam int CW = addr_w(IMG_W);
  localparam int RW = addr_w(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_TWO  = CW'(2);
  localparam logic [RW-1:0] ROW_TWO  = RW'(2);

  logic [CW-1:0] col, col_nxt, raddr;
  logic [RW-1:0] row, row_nxt;
  logic          accept, emit;
  logic [W-1:0]  lb0_rd, lb1_rd;
  logic [WIN_TAPS-1:0][W-1:0] win_p0, win_nxt;

  assign x.ready = !y_valid || y_ready;
  assign accept  = x.valid && x.ready;
  assign emit    = (row >= ROW_TWO) && (col >= COL_TWO);

  always_comb begin
    col_nxt = col + 1'b1;
    row_nxt = row;
    if (col == COL_LAST) begin
      col_nxt = '0;
      row_nxt = (row == ROW_LAST) ? '0 : row + 1'b1;
    end
  end

  // Prefetch the next column on accept so its line data is ready on the following beat.
  assign raddr = accept ? col_nxt : col;

  line_buffer_ram #(.DEPTH(IMG_W), .WIDTH(W)) u_lb0 (
    .clk   (clk),
    .we    (accept && rst_n),
    .waddr (col),
    .wdata (x.data),
    .raddr (raddr),
    .rdata (lb0_rd)
  );

  line_buffer_ram #(.DEPTH(IMG_W), .WIDTH(W)) u_lb1 (
    .clk   (clk),
    .we    (accept && rst_n),
    .waddr (col),
    .wdata (lb0_rd),
    .raddr (raddr),
    .rdata (lb1_rd)
  );

  always_comb begin
    win_nxt = win_p0;
    for (int i = 0; i < 3; i++) begin
      win_nxt[3*i]   = win_p0[3*i+1];
      win_nxt[3*i+1] = win_p0[3*i+2];
    end
    win_nxt[2] = lb1_rd;
    win_nxt[5] = lb0_rd;
    win_nxt[8] = x.data;
  end

  // p0 -> output register: window leaves one cycle after the pixel that completes it
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col     <= '0;
      row     <= '0;
      win_p0  <= '0;
      y_valid <= 1'b0;
      y_win   <= '0;
`ifdef WIN_SOF_EN
      y_sof   <= 1'b0;
`endif
    end else if (accept) begin
      col     <= col_nxt;
      row     <= row_nxt;
      win_p0  <= win_nxt;
      y_valid <= emit;
      if (emit) begin
        y_win <= win_nxt;
`ifdef WIN_SOF_EN
        y_sof <= (row == ROW_TWO) && (col == COL_TWO);
`endif
      end
    end else if (y_ready) begin
      y_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_conv_window_gen.sv
// Directed bench for conv_window_gen on a 4x4 image with pixel value 4*r+c (+ frame offset).
module tb_conv_window_gen;
  import conv_pkg::*;
  localparam int W  = 30;
  localparam int IW = 4;
  localparam int IH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic y_ready = 1'b1;
  logic y_valid;
  logic [WIN_TAPS*W-1:0] y_win;
`ifdef WIN_SOF_EN
  logic y_sof;
  bit   obs_sof[$];
`endif

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int acc10_cyc = -1;
  window_t obs_win[$];
  int      obs_cyc[$];
  window_t exp_q[$];

  dstream #(.N(W)) x_if ();

  conv_window_gen #(.W(W), .IMG_W(IW), .IMG_H(IH)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .x       (x_if),
    .y_win   (y_win),
    .y_valid (y_valid),
    .y_ready (y_ready)
`ifdef WIN_SOF_EN
    ,
    .y_sof   (y_sof)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Record every window that transfers at the coming rising edge.
  always @(negedge clk) begin
    #2;
    if (rst_n && y_valid && y_ready) begin
      obs_win.push_back(window_t'(y_win));
      obs_cyc.push_back(cyc);
`ifdef WIN_SOF_EN
      obs_sof.push_back(y_sof);
`endif
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  function automatic window_t exp_win(input int off, input int r, input int c);
    window_t w;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        w[3*i+j] = pixel_t'(off + IW*(r-2+i) + (c-2+j));
    return w;
  endfunction

  task automatic push_frame(input int off);
    for (int r = 2; r < IH; r++)
      for (int c = 2; c < IW; c++)
        exp_q.push_back(exp_win(off, r, c));
  endtask

  task automatic clear_obs();
    obs_win.delete();
    obs_cyc.delete();
    exp_q.delete();
`ifdef WIN_SOF_EN
    obs_sof.delete();
`endif
  endtask

  // Drive n pixels of one frame; optional 1-in-3 y_ready throttle and random valid gaps.
  task automatic drive(input int off, input int n, input bit throttle,
                       input int gap_pct, input bit gap_chk);
    int idx = 0;
    int spent = 0;
    bit prev_acc = 1'b1;
    bit prev_stall = 1'b0;
    window_t prev_win = '0;
    while (idx < n && spent < 400) begin
      @(negedge clk);
      y_ready    = throttle ? (cyc % 3 == 0) : 1'b1;
      x_if.valid = (gap_pct == 0) || ($urandom_range(99) >= gap_pct);
      x_if.data  = W'(off + idx);
      #1;
      if (prev_stall) begin
        total++;
        if (y_valid !== 1'b1 || window_t'(y_win) !== prev_win) begin
          bad++;
          $display("FAIL stall_hold: valid=%b win=%h, required valid=1 win=%h", y_valid, y_win, prev_win);
        end
      end
      if (y_valid && !y_ready) begin
        total++;
        if (x_if.ready !== 1'b0) begin
          bad++;
          $display("FAIL ready_stall: x.ready=%b, required 0", x_if.ready);
        end
      end
      if (gap_chk && !prev_acc) begin
        total++;
        if (y_valid !== 1'b0) begin
          bad++;
          $display("FAIL gap_quiet: y_valid=%b after idle beat, required 0", y_valid);
        end
      end
      prev_stall = y_valid && !y_ready;
      prev_win   = window_t'(y_win);
      prev_acc   = x_if.valid && x_if.ready;
      if (prev_acc) begin
        if (idx == 10) acc10_cyc = cyc + 1;
        idx++;
      end
      spent++;
    end
    if (idx < n) begin
      total++;
      bad++;
      $display("FAIL drive_timeout: accepted %0d pixels, required %0d", idx, n);
    end
  endtask

  task automatic drain();
    @(negedge clk);
    x_if.valid = 1'b0;
    y_ready    = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic test_reset();
    x_if.valid = 1'b0;
    x_if.data  = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (y_valid !== 1'b0 || y_win !== '0) begin
      bad++;
      $display("FAIL reset_out: valid=%b win=%h, required 0/0", y_valid, y_win);
    end
`ifdef WIN_SOF_EN
    total++;
    if (y_sof !== 1'b0) begin
      bad++;
      $display("FAIL reset_sof: y_sof=%b, required 0", y_sof);
    end
`endif
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    total++;
    if (x_if.ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_ready: x.ready=%b, required 1", x_if.ready);
    end
  endtask

  task automatic test_single_frame();
    int first_taps[9] = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
    int last_taps[9]  = '{5, 6, 7, 9, 10, 11, 13, 14, 15};
    clear_obs();
    push_frame(0);
    drive(0, 16, 1'b0, 0, 1'b0);
    drain();
    total++;
    if (obs_win.size() != 4) begin
      bad++;
      $display("FAIL single_count: got %0d windows, required 4", obs_win.size());
    end
    for (int k = 0; k < exp_q.size() && k < obs_win.size(); k++) begin
      total++;
      if (obs_win[k] !== exp_q[k]) begin
        bad++;
        $display("FAIL single_win%0d: got %h, required %h", k, obs_win[k], exp_q[k]);
      end
    end
    if (obs_win.size() == 4) begin
      for (int k = 0; k < 9; k++) begin
        total++;
        if (obs_win[0][k] !== pixel_t'(first_taps[k]) || obs_win[3][k] !== pixel_t'(last_taps[k])) begin
          bad++;
          $display("FAIL single_tap%0d: first=%0d last=%0d, required %0d/%0d",
                   k, obs_win[0][k], obs_win[3][k], first_taps[k], last_taps[k]);
        end
      end
      total++;
      if (obs_cyc[0] != acc10_cyc) begin
        bad++;
        $display("FAIL single_latency: first window at cycle %0d, required %0d", obs_cyc[0], acc10_cyc);
      end
    end
  endtask

  task automatic test_throttle();
    clear_obs();
    push_frame(0);
    drive(0, 16, 1'b1, 0, 1'b0);
    drain();
    total++;
    if (obs_win.size() != 4) begin
      bad++;
      $display("FAIL throttle_count: got %0d windows, required 4", obs_win.size());
    end
    for (int k = 0; k < exp_q.size() && k < obs_win.size(); k++) begin
      total++;
      if (obs_win[k] !== exp_q[k]) begin
        bad++;
        $display("FAIL throttle_win%0d: got %h, required %h", k, obs_win[k], exp_q[k]);
      end
    end
  endtask

  task automatic test_back_to_back();
    window_t f2_first;
    int f2_taps[9] = '{100, 101, 102, 104, 105, 106, 108, 109, 110};
    for (int k = 0; k < 9; k++) f2_first[k] = pixel_t'(f2_taps[k]);
    clear_obs();
    push_frame(0);
    push_frame(100);
    drive(0, 16, 1'b0, 0, 1'b0);
    drive(100, 16, 1'b0, 0, 1'b0);
    drain();
    total++;
    if (obs_win.size() != 8) begin
      bad++;
      $display("FAIL b2b_count: got %0d windows, required 8", obs_win.size());
    end
    for (int k = 0; k < exp_q.size() && k < obs_win.size(); k++) begin
      total++;
      if (obs_win[k] !== exp_q[k]) begin
        bad++;
        $display("FAIL b2b_win%0d: got %h, required %h", k, obs_win[k], exp_q[k]);
      end
    end
    if (obs_win.size() > 4) begin
      total++;
      if (obs_win[4] !== f2_first) begin
        bad++;
        $display("FAIL b2b_frame2_first: got %h, required %h", obs_win[4], f2_first);
      end
    end
`ifdef WIN_SOF_EN
    for (int k = 0; k < obs_sof.size(); k++) begin
      total++;
      if (obs_sof[k] !== (k == 0 || k == 4)) begin
        bad++;
        $display("FAIL sof%0d: y_sof=%b, required %b", k, obs_sof[k], (k == 0 || k == 4));
      end
    end
`endif
  endtask

  task automatic test_random_gaps();
    clear_obs();
    push_frame(0);
    drive(0, 16, 1'b0, 50, 1'b1);
    drain();
    total++;
    if (obs_win.size() != 4) begin
      bad++;
      $display("FAIL gaps_count: got %0d windows, required 4", obs_win.size());
    end
    for (int k = 0; k < exp_q.size() && k < obs_win.size(); k++) begin
      total++;
      if (obs_win[k] !== exp_q[k]) begin
        bad++;
        $display("FAIL gaps_win%0d: got %h, required %h", k, obs_win[k], exp_q[k]);
      end
    end
  endtask

  task automatic test_mid_frame_reset();
    clear_obs();
    drive(0, 10, 1'b0, 0, 1'b0);
    @(negedge clk);
    x_if.valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    total++;
    if (y_valid !== 1'b0) begin
      bad++;
      $display("FAIL midreset_valid: y_valid=%b, required 0", y_valid);
    end
    push_frame(0);
    drive(0, 16, 1'b0, 0, 1'b0);
    drain();
    total++;
    if (obs_win.size() != 4) begin
      bad++;
      $display("FAIL midreset_count: got %0d windows, required 4", obs_win.size());
    end
    for (int k = 0; k < exp_q.size() && k < obs_win.size(); k++) begin
      total++;
      if (obs_win[k] !== exp_q[k]) begin
        bad++;
        $display("FAIL midreset_win%0d: got %h, required %h", k, obs_win[k], exp_q[k]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_throttle();
    test_back_to_back();
    test_random_gaps();
    test_mid_frame_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
